// File: rtl/gf2_31_pkg.sv
// Shared constants and FSM state type for the degree-31 GF(2) PRNG datapath.
// The affine stage, the modular reducer and the PRNG top all import this package.
package gf2_31_pkg;

  localparam int GF2_31_DEG   = 31;
  localparam int GF2_31_AFF_W = 35;
  localparam logic [GF2_31_DEG:0] GF2_31_MOD_POLY = 32'h8000_0009;

  // The counter must also be able to hold IN_W itself for the range check.
  localparam int GF2_31_CNT_W = $clog2(GF2_31_AFF_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } red_state_e;

endpackage

// File: rtl/gf2_poly_reduce_step.sv
// One step of GF(2) long division: clear bit cnt of rem by XORing in
// m(x) * x^(cnt-OUT_W) when that bit is set.
module gf2_poly_reduce_step #(
  parameter int             IN_W     = 35,
  parameter int             OUT_W    = 31,
  parameter int             CNT_W    = 6,
  parameter logic [OUT_W:0] MOD_POLY = 32'h8000_0009
) (
  input  logic [IN_W-1:0]  rem_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [IN_W-1:0]  rem_o
);

  logic [IN_W-1:0]  poly_ext;
  logic [IN_W-1:0]  poly_shift;
  logic [CNT_W-1:0] shamt;
  logic             in_range;

  always_comb begin
    poly_ext            = '0;
    poly_ext[OUT_W:0]   = MOD_POLY;
    shamt               = cnt_i - CNT_W'(OUT_W);
    poly_shift          = poly_ext << shamt;
    // Outside OUT_W..IN_W-1 the shift would wrap, so the step is a pass-through.
    in_range            = (cnt_i >= CNT_W'(OUT_W)) && (cnt_i < CNT_W'(IN_W));
    rem_o               = rem_i;
    if (in_range && rem_i[cnt_i]) begin
      rem_o = rem_i ^ poly_shift;
    end
  end

endmodule

// File: rtl/gf2_poly_mod_reduce_31.sv
// Sequential reduction of the affine-stage output modulo m(x) = x^31 + x^3 + 1,
// one high-order bit per cycle, with valid/ready handshakes on both sides.
module gf2_poly_mod_reduce_31
  import gf2_31_pkg::*;
#(
  parameter int             IN_W     = GF2_31_AFF_W,
  parameter int             OUT_W    = GF2_31_DEG,
  parameter logic [OUT_W:0] MOD_POLY = GF2_31_MOD_POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_poly,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_poly
);

  localparam int CNT_W = $clog2(IN_W + 1);

  generate
    if (IN_W <= OUT_W || MOD_POLY[OUT_W] != 1'b1) begin : g_bad_params
      $error("gf2_poly_mod_reduce_31: need IN_W > OUT_W and MOD_POLY[OUT_W] set");
    end
  endgenerate

  red_state_e       state_q, state_d;
  logic [IN_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  rem_step;

  gf2_poly_reduce_step #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .CNT_W    (CNT_W),
    .MOD_POLY (MOD_POLY)
  ) u_step (
    .rem_i (rem_q),
    .cnt_i (cnt_q),
    .rem_o (rem_step)
  );

  // NOTE: the working register is reset too, so an aborted operand never
  // leaks onto out_poly after a mid-operation reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: hold values assigned first so no path through the case infers a latch.
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = in_poly;
          cnt_d   = CNT_W'(IN_W - 1);
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        rem_d = rem_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(OUT_W)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_poly  = rem_q[OUT_W-1:0];

endmodule

// File: doc/gf2_poly_mod_reduce_31.md
Name: gf2_poly_mod_reduce_31

Overview:
Sequential modular-reduction stage placed directly downstream of gf2_poly_affine_31. It takes the 35-bit product-plus-constant a(x)p(x)+c(x) and reduces it modulo the degree-31 primitive polynomial m(x) = x^31 + x^3 + 1, one high-order bit per cycle. The 31-bit remainder is the next PRNG state, so it closes the state-update loop p <- (a(x)p(x) + c(x)) mod m(x). Both sides use valid/ready handshakes.

Parameters:
IN_W, 35, width of in_poly; must equal the affine stage output width
OUT_W, 31, width of out_poly; degree of m(x)
MOD_POLY, 32'h8000_0009, m(x) with the x^31 term included (bit OUT_W set)

Ports:
clk  input  1  system clock; all logic is rising-edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  in_poly is valid
in_ready  output  1  block can accept an operand
in_poly  input  IN_W  unreduced polynomial; bit i is the coefficient of x^i
out_valid  output  1  out_poly holds a reduced result
out_ready  input  1  downstream accepts the result
out_poly  output  OUT_W  remainder (in_poly mod m(x))

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: rst_n sampled low at a rising edge of clk resets the block.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_poly=0, working register rem=0, bit counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch rem<=in_poly and cnt<=IN_W-1, then go to REDUCE.
  - REDUCE: in_ready=0. Each cycle, if rem[cnt]==1 then rem <= rem ^ (MOD_POLY << (cnt-OUT_W)); then cnt<=cnt-1. The step with cnt==OUT_W is the last step and moves to DONE.
  - DONE: out_valid=1, out_poly=rem[OUT_W-1:0]. On out_ready, go to IDLE.
- Latency: handshake accepted at edge T. REDUCE runs on edges T+1..T+(IN_W-OUT_W), i.e. 4 cycles. out_valid is high from T+5.
- Throughput: one result per 6 cycles when out_ready is held high. in_ready returns the cycle after the output handshake.
- Backpressure: while out_valid && !out_ready, out_poly is held stable and no new input is accepted.
- in_valid while in_ready=0 is ignored; no data is captured.
- Arithmetic:
  - GF(2) only: XOR, no carries.
  - After the REDUCE phase, bits IN_W-1..OUT_W of rem are 0; the bench checks this with an assertion.
  - The shift amount is always in 0..IN_W-OUT_W-1, so no term of the shifted MOD_POLY exceeds bit IN_W-1.
- Inputs with no bits set above OUT_W-1 still take the full 4 REDUCE cycles. Latency is constant and data-independent.
- Reset mid-operation: rst_n low in REDUCE or DONE discards the in-flight data and returns every output to its reset value on that edge. No result is emitted.
- Elaboration check: IN_W > OUT_W, and MOD_POLY[OUT_W]==1.

Decomposition:
- Shared package gf2_31_pkg holds:
  - constants GF2_31_DEG=31, GF2_31_AFF_W=35 and GF2_31_MOD_POLY=32'h8000_0009;
  - the FSM state typedef {IDLE, REDUCE, DONE}.
  The affine stage wrapper and the PRNG top reuse the same constants.
- One combinational sub-module: gf2_poly_reduce_step. It takes rem and cnt and returns rem conditionally XORed with the shifted MOD_POLY. This keeps a single-step reference that the bench can also call in its model.

Test Plan:
- in_poly=35'h1 -> out_poly=31'h1 after 5 cycles; REDUCE makes no change.
- in_poly=1<<31 -> out_poly=31'h9 (x^31 mod m = x^3+1).
- in_poly=1<<34 -> out_poly=31'h48. in_poly=(1<<34)|(1<<31) -> out_poly=31'h41, which exercises a two-step chain.
- in_poly=(1<<33)|1 with out_ready held low for 7 cycles:
  - out_poly=31'h25 must stay stable with out_valid=1 and in_ready=0;
  - a stray in_valid during this window is ignored;
  - releasing out_ready returns in_ready=1 on the next cycle.
- Back-to-back random 35-bit operands with out_ready=1, compared against a bit-serial software model:
  - throughput is exactly one result per 6 cycles;
  - the upper-bits-zero assertion holds.
- rst_n pulsed low during the second REDUCE cycle:
  - the next edge gives out_valid=0, in_ready=1, out_poly=0;
  - no result appears for the aborted operand;
  - the next operand reduces correctly.
